// File: rtl/fp12_pkg.sv
// Shared definitions for the 12-bit floating-point sequential multiplier.
// Format: {sign, exp[3:0], mant[6:0]} with a hidden leading 1; every encoding is normalized.
// Contents: field widths, default exponent bias, derived significand/product widths and the
// controller state type.
package fp12_pkg;

  localparam int unsigned EXP_W    = 4;
  localparam int unsigned MAN_W    = 7;
  localparam int unsigned WORD_W   = 12;
  localparam int unsigned BIAS_DEF = 7;

  // Significand includes the hidden 1; the product is the full double-width result.
  localparam int unsigned SIG_W  = MAN_W + 1;
  localparam int unsigned PROD_W = 2 * SIG_W;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StNorm,
    StDone
  } state_e;

endpackage

// File: rtl/fp12_normalize.sv
// Combinational normalization stage of fp12_mul_seq.
// Takes the original operands (for signs and exponents) and the raw 16-bit significand
// product, and forms the packed result together with exponent overflow/underflow flags.
// Mantissa is truncated, never rounded.
// Build option: FP12_MUL_SAT_EN -- when defined, an out-of-range exponent saturates the
// result (max magnitude on overflow, signed zero on underflow); otherwise the exponent
// field wraps to the low 4 bits of the computed exponent. Flags are reported either way.
// Ports:
//   x_i, y_i  operands {sign, exp, mant}
//   prod_i    unsigned product of the two 8-bit significands
//   z_o       packed result
//   ovf_o     computed exponent above 15
//   unf_o     computed exponent below 0
module fp12_normalize
  import fp12_pkg::*;
#(
  parameter int unsigned BIAS = BIAS_DEF
) (
  input  logic [WORD_W-1:0] x_i,
  input  logic [WORD_W-1:0] y_i,
  input  logic [PROD_W-1:0] prod_i,
  output logic [WORD_W-1:0] z_o,
  output logic              ovf_o,
  output logic              unf_o
);

  localparam logic [5:0] BiasE = 6'(BIAS);

  logic             sign;
  logic             top;
  logic [5:0]       exp_s;
  logic [MAN_W-1:0] mant;

  always_comb begin
    sign = x_i[WORD_W-1] ^ y_i[WORD_W-1];
    top  = prod_i[PROD_W-1];
    // 6-bit two's complement: range -7..24 for the default bias, so no aliasing.
    exp_s = {2'b00, x_i[WORD_W-2:MAN_W]} + {2'b00, y_i[WORD_W-2:MAN_W]}
          + {5'b00000, top} - BiasE;
    mant  = top ? prod_i[PROD_W-2:SIG_W] : prod_i[PROD_W-3:SIG_W-1];
    unf_o = exp_s[5];
    ovf_o = ~exp_s[5] & exp_s[4];
`ifdef FP12_MUL_SAT_EN
    if (ovf_o) begin
      z_o = {sign, 4'hF, 7'h7F};
    end else if (unf_o) begin
      z_o = {sign, 11'h000};
    end else begin
      z_o = {sign, exp_s[3:0], mant};
    end
`else
    z_o = {sign, exp_s[3:0], mant};
`endif
  end

endmodule

// File: rtl/fp12_mul_seq.sv
// Sequential 12-bit floating-point multiplier.
// Accepts one operand pair in IDLE, runs eight shift-add iterations (one per cycle,
// multiplier LSB first), normalizes in one cycle, then holds the result until taken.
// out_valid rises 9 cycles after the acceptance edge.
// Build option: FP12_MUL_SAT_EN (see fp12_normalize) selects saturation of z on
// exponent overflow/underflow instead of wrap-around.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  operand handshake; in_ready only in IDLE
//   x, y                 operands {sign, exp[3:0], mant[6:0]}
//   out_valid/out_ready  result handshake; z/ovf/unf stable while out_valid
//   z, ovf, unf          product and exponent overflow/underflow flags
//   busy                 any state other than IDLE
module fp12_mul_seq
  import fp12_pkg::*;
#(
  parameter int unsigned BIAS = BIAS_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] x,
  input  logic [WORD_W-1:0] y,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] z,
  output logic              ovf,
  output logic              unf,
  output logic              busy
);

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [PROD_W-1:0] acc_q, acc_d;
  logic [WORD_W-1:0] x_q, x_d, y_q, y_d;
  logic [WORD_W-1:0] z_q, z_d;
  logic              ovf_q, ovf_d, unf_q, unf_d;

  logic [SIG_W-1:0]  sig_x, sig_y;
  logic [WORD_W-1:0] norm_z;
  logic              norm_ovf, norm_unf;

  assign sig_x = {1'b1, x_q[MAN_W-1:0]};
  assign sig_y = {1'b1, y_q[MAN_W-1:0]};

  fp12_normalize #(
    .BIAS (BIAS)
  ) u_normalize (
    .x_i    (x_q),
    .y_i    (y_q),
    .prod_i (acc_q),
    .z_o    (norm_z),
    .ovf_o  (norm_ovf),
    .unf_o  (norm_unf)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          x_d     = x;
          y_d     = y;
          cnt_d   = 3'd0;
          acc_d   = '0;
          state_d = StMul;
        end
      end
      StMul: begin
        if (sig_y[cnt_q]) begin
          acc_d = acc_q + ({{SIG_W{1'b0}}, sig_x} << cnt_q);
        end
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'(SIG_W - 1)) begin
          state_d = StNorm;
        end
      end
      StNorm: begin
        z_d     = norm_z;
        ovf_d   = norm_ovf;
        unf_d   = norm_unf;
        state_d = StDone;
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 3'd0;
      acc_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign out_valid = (state_q == StDone);
  assign z         = z_q;
  assign ovf       = ovf_q;
  assign unf       = unf_q;

endmodule

// File: doc/fp12_mul_seq.md
FP12_MUL_SEQ -- requirements
Module: fp12_mul_seq

Interface
REQ-001 SHALL have parameter BIAS, default 7, exponent bias of the 12-bit format (1 sign, 4 exponent, 7 mantissa, hidden leading 1).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  operand pair x/y present.
REQ-005 SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-006 SHALL have ports x, y  input  12 each  operands {sign, exp[3:0], mant[6:0]}.
REQ-007 SHALL have port out_valid  output  1  result z valid.
REQ-008 SHALL have port out_ready  input  1  consumer takes z this cycle.
REQ-009 SHALL have port z  output  12  product.
REQ-010 SHALL have ports ovf, unf  output  1 each  exponent overflow/underflow of the current z.
REQ-011 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, MUL, NORM, DONE.
REQ-013 SHALL assert in_ready only in IDLE; acceptance = in_valid && in_ready at a rising edge; operands are captured and the FSM moves IDLE->MUL with bit counter 0.
REQ-014 SHALL in MUL perform one shift-add iteration per cycle on 8-bit mantissas {1,mant} (multiplier LSB first) into a 16-bit accumulator; counter 7 moves MUL->NORM.
REQ-015 SHALL in NORM compute: sign = xs^ys; P = 16-bit product; e = xe + ye - BIAS + P[15] in 6-bit signed; mant = P[15] ? P[14:8] : P[13:7] (truncation, no rounding); then NORM->DONE.
REQ-016 SHALL assert out_valid 9 cycles after the acceptance edge and hold z, ovf, unf, out_valid stable in DONE until out_ready is high.
REQ-017 SHALL move DONE->IDLE on out_ready; out_valid deasserts the following cycle; no new operand is accepted in the cycle out_ready is taken (in_ready rises the cycle after).
REQ-018 SHALL set ovf = (e > 15) and unf = (e < 0); both are registered with z.
REQ-019 SHALL treat every encoding as normalized (no zero, inf or NaN special cases).
REQ-020 SHALL ignore in_valid, x, y in MUL, NORM, DONE; x/y changes after acceptance have no effect.

Reset
REQ-021 SHALL on rst_n low, asynchronously: state IDLE, counter 0, accumulator 0, z = 0, ovf = unf = 0, out_valid = 0, busy = 0; in_ready = 1 once state is IDLE.
REQ-022 SHALL discard any in-flight operation when reset asserts mid-MUL/NORM/DONE; no out_valid follows release.

Configuration
REQ-023 SHALL with FP12_MUL_SAT_EN defined: on ovf z = {sign, 4'hF, 7'h7F}; on unf z = {sign, 11'h000}.
REQ-024 SHALL without FP12_MUL_SAT_EN: z exponent = e[3:0] (wrap-around), flags still reported.

Structure
REQ-025 SHALL place widths (EXP_W=4, MAN_W=7, WORD_W=12), default BIAS and the FSM state enum in shared package fp12_pkg.
REQ-026 SHALL place normalization, exponent computation, flag and saturation logic in one combinational sub-module fp12_normalize; the FSM, counter and accumulator stay in fp12_mul_seq.

Verification
REQ-027 SHALL cover: x=0x380 (1.0), y=0x380 -> z=0x380, ovf=unf=0, out_valid exactly 9 cycles after acceptance.
REQ-028 SHALL cover: x=0x3C0 (1.5), y=0x3C0 -> z=0x410 (2.25, P[15]=1 path); x=0xB80, y=0x3C0 -> z=0xBC0.
REQ-029 SHALL cover: x=y=0x780 -> ovf=1; z=0x7FF with FP12_MUL_SAT_EN, z=0x380 without.
REQ-030 SHALL cover: x=y=0x080 -> unf=1; z=0x000 with FP12_MUL_SAT_EN, z=0x580 without.
REQ-031 SHALL cover: out_ready held low 5 cycles in DONE -> z/flags stable, in_ready=0; then two back-to-back operations -> second acceptance one cycle after out_ready.
REQ-032 SHALL cover: rst_n pulsed low in MUL cycle 4 -> outputs at reset values immediately, in_ready=1 after release, no spurious out_valid.
